// File: rtl/csr_unit.sv
// Purpose : machine-mode CSR file and trap controller in the MW stage.
// Latency : reads and redirects are combinational; writes and trap state commit at the next clk edge.
// Backpr. : stall freezes all CSR state except mip and suppresses trap entry, mret and redirects.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   stall, valid_MW                 pipeline hold / MW instruction is real
//   csr_reg_rdMW, csr_reg_wrMW      MW instruction reads / writes a CSR
//   is_mretMW                       MW instruction is mret
//   csr_op, csr_addr, csr_wdata     write operation (01 RW, 10 RS, 11 RC), address, operand
//   pcMW                            PC of the MW instruction (saved to mepc on trap)
//   timer_intr, ext_intr            level interrupt requests
//   csr_rdata                       old CSR value (0 when not reading)
//   epc_taken, epc_out              fetch redirect and its target
//   intr_flush                      squash MW and younger stages
module csr_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            valid_MW,
   input  logic            csr_reg_rdMW,
   input  logic            csr_reg_wrMW,
   input  logic            is_mretMW,
   input  logic [1:0]      csr_op,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   input  logic [XLEN-1:0] pcMW,
   input  logic            timer_intr,
   input  logic            ext_intr,
   output logic [XLEN-1:0] csr_rdata,
   output logic            epc_taken,
   output logic [XLEN-1:0] epc_out,
   output logic            intr_flush
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MIE     = 12'h304;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MIP     = 12'h344;

   // Writable-bit masks; bits outside a mask are hardwired to zero.
   localparam logic [XLEN-1:0] MSTATUS_WMASK = XLEN'(32'h0000_0088);
   localparam logic [XLEN-1:0] MIE_WMASK     = XLEN'(32'h0000_0880);
   localparam logic [XLEN-1:0] MTVEC_WMASK   = {{(XLEN-2){1'b1}}, 2'b01};
   localparam logic [XLEN-1:0] MEPC_WMASK    = {{(XLEN-2){1'b1}}, 2'b00};

   localparam int MIE_BIT  = 3;
   localparam int MPIE_BIT = 7;

   logic [XLEN-1:0] mstatus, mie, mtvec, mepc, mcause, mip;
   logic [XLEN-1:0] rd_val, wr_val, mip_nxt, pend, vec_base, vec_off, mcause_trap;
   logic [3:0]      cause_code;
   logic            trap_take, mret_take, wr_commit;

   // Combinational read of the addressed CSR (old value, no bypass).
   always_comb begin
      rd_val = '0;
      unique case (csr_addr)
         ADDR_MSTATUS: rd_val = mstatus;
         ADDR_MIE:     rd_val = mie;
         ADDR_MTVEC:   rd_val = mtvec;
         ADDR_MEPC:    rd_val = mepc;
         ADDR_MCAUSE:  rd_val = mcause;
         ADDR_MIP:     rd_val = mip;
         default:      rd_val = '0;
      endcase
   end

   assign csr_rdata = csr_reg_rdMW ? rd_val : '0;

   // New value is derived from the unmasked operand; masking happens on commit.
   always_comb begin
      wr_val = rd_val;
      unique case (csr_op)
         2'b01:   wr_val = csr_wdata;
         2'b10:   wr_val = rd_val | csr_wdata;
         2'b11:   wr_val = rd_val & ~csr_wdata;
         default: wr_val = rd_val;
      endcase
   end

   always_comb begin
      mip_nxt     = '0;
      mip_nxt[7]  = timer_intr;
      mip_nxt[11] = ext_intr;
   end

   // Global MIE gates every pending source; external beats timer.
   assign pend        = mip & mie & {XLEN{mstatus[MIE_BIT]}};
   assign cause_code  = pend[11] ? 4'd11 : 4'd7;
   assign trap_take   = (|pend) && valid_MW && !stall;
   assign mret_take   = is_mretMW && valid_MW && !stall && !trap_take;
   assign vec_base    = {mtvec[XLEN-1:2], 2'b00};
   assign vec_off     = {{(XLEN-6){1'b0}}, cause_code, 2'b00};
   assign mcause_trap = {1'b1, {(XLEN-5){1'b0}}, cause_code};

   always_comb begin
      epc_taken  = 1'b0;
      intr_flush = 1'b0;
      epc_out    = '0;
      if (trap_take) begin
         epc_taken  = 1'b1;
         intr_flush = 1'b1;
         epc_out    = mtvec[0] ? (vec_base + vec_off) : vec_base;
      end else if (mret_take) begin
         epc_taken = 1'b1;
         epc_out   = mepc;
      end
   end

   assign wr_commit = csr_reg_wrMW && valid_MW && !stall && !intr_flush && (csr_op != 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mstatus <= '0;
         mie     <= '0;
         mtvec   <= '0;
         mepc    <= '0;
         mcause  <= '0;
         mip     <= '0;
      end else begin
         mip <= mip_nxt;
         if (wr_commit) begin
            unique case (csr_addr)
               ADDR_MSTATUS: mstatus <= wr_val & MSTATUS_WMASK;
               ADDR_MIE:     mie     <= wr_val & MIE_WMASK;
               ADDR_MTVEC:   mtvec   <= wr_val & MTVEC_WMASK;
               ADDR_MEPC:    mepc    <= wr_val & MEPC_WMASK;
               ADDR_MCAUSE:  mcause  <= wr_val;
               default:      ;
            endcase
         end
         // Trap and mret field updates override a same-cycle mstatus write.
         if (trap_take) begin
            mepc              <= pcMW & MEPC_WMASK;
            mcause            <= mcause_trap;
            mstatus[MPIE_BIT] <= mstatus[MIE_BIT];
            mstatus[MIE_BIT]  <= 1'b0;
         end else if (mret_take) begin
            mstatus[MIE_BIT]  <= mstatus[MPIE_BIT];
            mstatus[MPIE_BIT] <= 1'b1;
         end
      end
   end

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode CSR file and trap controller in the memory/writeback (MW) stage. It consumes the MW-stage control bits `csr_reg_rdMW`, `csr_reg_wrMW` and `is_mretMW`, and performs CSR reads and writes. It takes timer and external interrupts, and redirects the fetch PC on trap entry and on `mret`. It holds `mstatus`, `mie`, `mip`, `mtvec`, `mepc` and `mcause`, and asserts `intr_flush` so the pipeline squashes the MW instruction when an interrupt is taken.

## Interface
- `XLEN`, 32, data and PC width.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `stall`  in  1  pipeline stall; freezes all CSR state and suppresses trap entry.
- `valid_MW`  in  1  MW stage holds a real (non-bubble) instruction.
- `csr_reg_rdMW`  in  1  MW instruction reads a CSR.
- `csr_reg_wrMW`  in  1  MW instruction writes a CSR.
- `is_mretMW`  in  1  MW instruction is `mret`.
- `csr_op`  in  2  write operation: 01 write (RW), 10 set (RS), 11 clear (RC); 00 means no write.
- `csr_addr`  in  12  CSR address from the MW instruction.
- `csr_wdata`  in  XLEN  operand (rs1 value or zero-extended immediate).
- `pcMW`  in  XLEN  PC of the MW instruction.
- `timer_intr`  in  1  level timer interrupt request.
- `ext_intr`  in  1  level external interrupt request.
- `csr_rdata`  out  XLEN  old CSR value; goes to writeback when `wb_sel` selects CSR.
- `epc_taken`  out  1  fetch PC must be replaced by `epc_out` this cycle.
- `epc_out`  out  XLEN  redirect target.
- `intr_flush`  out  1  squash the MW instruction and all younger stages.

## Operation
- Implemented CSRs and their writable bits:
  - `mstatus` 0x300: bits 3 (MIE) and 7 (MPIE) only.
  - `mie` 0x304: bits 7 (MTIE) and 11 (MEIE) only.
  - `mtvec` 0x305: bits [31:2] are BASE; bit 0 is MODE; bit 1 is hardwired 0.
  - `mepc` 0x341: bits [1:0] are hardwired 0.
  - `mcause` 0x342: full width.
  - `mip` 0x344: read-only; bit 7 = registered `timer_intr`, bit 11 = registered `ext_intr`.
- Unimplemented addresses read 0; writes to them are ignored.
- `csr_rdata` is a combinational read of `csr_addr`. It is returned whenever `csr_reg_rdMW` is set, and is 0 otherwise.
- Write value is computed from the old value before masking:
  - RW: `wdata`.
  - RS: `old | wdata`.
  - RC: `old & ~wdata`.
- A CSR write commits at the clock edge only when all of these hold: `csr_reg_wrMW`, `valid_MW`, `!stall`, `!intr_flush`.
- Interrupt pending check: `pend = mip & mie & {MIE}`. External (cause 11) has priority over timer (cause 7).
- Trap entry happens when `pend != 0`, `valid_MW` and `!stall`. That cycle:
  - Combinationally: `intr_flush = 1`, `epc_taken = 1`.
  - `epc_out` = BASE when MODE = 0; BASE + 4*cause when MODE = 1.
  - At the next edge: `mepc <= pcMW`, `mcause <= {1'b1, cause}`, `MPIE <= MIE`, `MIE <= 0`.
  - The MW instruction's CSR write and `mret` are discarded.
- `mret`, taken when `is_mretMW`, `valid_MW`, `!stall` and there is no trap entry:
  - Combinationally: `epc_taken = 1`, `epc_out = mepc`.
  - At the next edge: `MIE <= MPIE`, `MPIE <= 1`.
  - `intr_flush` stays 0.
- Otherwise `epc_taken = 0`, `intr_flush = 0`, `epc_out = 0`.
- `mip` sampling: `mip[7] <= timer_intr` and `mip[11] <= ext_intr` every cycle, regardless of `stall`.

## Timing
- Reset (`rst_n` low, asynchronous): all six CSRs clear to 0. With stage inputs at 0, outputs are `csr_rdata = 0`, `epc_taken = 0`, `epc_out = 0`, `intr_flush = 0`.
- Reset is independent of `clk`. Deassertion takes effect at the next edge.
- CSR read has zero-cycle latency. A write is visible to a read one cycle later. There is no same-cycle bypass; read-after-write in the same cycle returns the old value.
- Interrupt latency: a request asserted before edge N sets `mip` at edge N. Trap entry can occur in cycle N if `valid_MW` is high and the enables allow it.
- `stall` high: no state changes except `mip`. `epc_taken` and `intr_flush` are forced to 0.
- Writing `mstatus`.MIE = 1 while an interrupt is pending: the trap is taken on the next valid instruction, not on the writing instruction.
- Reset mid-trap clears `mepc` and `mcause` immediately.

## Test plan
- Reset, then read all six CSR addresses plus 0x7C0 -> every read returns 0x0000_0000.
- RW 0x305 with 0x8000_0003 -> reads back 0x8000_0001. RS 0x304 with 0x880 -> 0x880. RC 0x304 with 0x080 -> 0x800. RW 0x341 with 0x123 -> 0x120.
- `mtvec` = 0x100 with MODE = 1, `mie` = 0x880, MIE = 1, `timer_intr` pulse, `valid_MW` with `pcMW` = 0x40 -> same cycle `intr_flush` = 1, `epc_taken` = 1, `epc_out` = 0x11C. Next cycle `mepc` = 0x40, `mcause` = 0x8000_0007, `mstatus` = 0x80.
- Same setup with both interrupts high -> cause 11, `epc_out` = 0x12C.
- Then `mret` -> `epc_taken` = 1, `epc_out` = 0x40, `intr_flush` = 0. Next cycle `mstatus` = 0x88.
- Interrupt pending with `stall` = 1 for 3 cycles -> no flush and no CSR change. The trap fires in the first unstalled valid cycle. A CSR write presented in that same cycle is discarded.
